// File: rtl/posit_pkg.sv
// Shared types for the posit unit: operation/format encodings, status flags,
// and the issue-arbiter FSM state.
package posit_pkg;

    typedef enum logic [3:0] {
        FMADD    = 4'd0,
        FNMSUB   = 4'd1,
        ADD      = 4'd2,
        MUL      = 4'd3,
        DIV      = 4'd4,
        SQRT     = 4'd5,
        SGNJ     = 4'd6,
        MINMAX   = 4'd7,
        CMP      = 4'd8,
        CLASSIFY = 4'd9,
        F2F      = 4'd10,
        F2I      = 4'd11,
        I2F      = 4'd12
    } operation_e;

    typedef enum logic [2:0] {
        RNE = 3'b000,
        RTZ = 3'b001,
        RDN = 3'b010,
        RUP = 3'b011,
        RMM = 3'b100,
        DYN = 3'b111
    } roundmode_e;

    typedef enum logic [1:0] {
        POSIT32    = 2'd0,
        POSIT16    = 2'd1,
        POSIT8     = 2'd2,
        POSIT16ALT = 2'd3
    } posit_format_e;

    typedef enum logic [1:0] {
        INT8  = 2'd0,
        INT16 = 2'd1,
        INT32 = 2'd2,
        INT64 = 2'd3
    } int_format_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Width of a requester ID for n requesters (n >= 2).
    function automatic int unsigned req_id_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_NUM_REQ = 2;
    localparam int unsigned REQ_ID_W        = req_id_width(DEFAULT_NUM_REQ);

endpackage

// File: rtl/posit_id_fifo.sv
// In-order FIFO of requester IDs with occupancy count and synchronous clear.
// DEPTH must be a power of two so the pointers wrap naturally.
module posit_id_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [DW-1:0]            push_data_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic [DW-1:0] mem_q [DEPTH];
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign push_ok = push_i && ((count_q != DEPTH_CNT) || pop_ok);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage has no reset; count_q gates every read, so stale entries are never observed.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/posit_issue_arbiter.sv
// Shares one posit_top PPU between NUM_REQ requesters: round-robin issue with a
// held grant, and in-order routing of results back to the issuing requester.
module posit_issue_arbiter
    import posit_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 2,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_OPERANDS = 3,
    parameter int unsigned MAX_OUTST    = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rst_ni,

    input  logic [NUM_REQ-1:0]                           req_valid_i,
    output logic [NUM_REQ-1:0]                           req_ready_o,
    input  logic [NUM_REQ-1:0][NUM_OPERANDS-1:0][WIDTH-1:0] req_operands_i,
    input  operation_e    [NUM_REQ-1:0]                  req_op_i,
    input  logic [NUM_REQ-1:0]                           req_op_mod_i,
    input  roundmode_e    [NUM_REQ-1:0]                  req_rnd_mode_i,
    input  posit_format_e [NUM_REQ-1:0]                  req_src_fmt_i,
    input  posit_format_e [NUM_REQ-1:0]                  req_dst_fmt_i,
    input  int_format_e   [NUM_REQ-1:0]                  req_int_fmt_i,

    output logic [NUM_REQ-1:0]                           rsp_valid_o,
    input  logic [NUM_REQ-1:0]                           rsp_ready_i,
    output logic [WIDTH-1:0]                             rsp_result_o,
    output status_t                                      rsp_status_o,

    input  logic                                         flush_i,

    output logic [NUM_OPERANDS-1:0][WIDTH-1:0]           ppu_operands_o,
    output operation_e                                   ppu_op_o,
    output logic                                         ppu_op_mod_o,
    output roundmode_e                                   ppu_rnd_mode_o,
    output posit_format_e                                ppu_src_fmt_o,
    output posit_format_e                                ppu_dst_fmt_o,
    output int_format_e                                  ppu_int_fmt_o,
    output logic                                         ppu_in_valid_o,
    output logic                                         ppu_flush_o,
    input  logic                                         ppu_in_ready_i,
    input  logic                                         ppu_out_valid_i,
    output logic                                         ppu_out_ready_o,
    input  logic [WIDTH-1:0]                             ppu_result_i,
    input  status_t                                      ppu_status_i,
    input  logic                                         ppu_busy_i,

    output logic                                         busy_o,
    output logic                                         protocol_err_o
);

    localparam int unsigned IDW = req_id_width(NUM_REQ);
    localparam int unsigned CW  = $clog2(MAX_OUTST) + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTST);

    typedef logic [IDW-1:0] req_id_t;

    arb_state_e    state_q, state_d;
    req_id_t       rr_ptr_q, rr_ptr_d;
    req_id_t       lock_id_q, lock_id_d;
    req_id_t       pick_id, grant_id, head_id;
    logic          pick_vld, grant_vld, accept;
    logic          has_outst, can_issue, pop;
    logic [CW-1:0] count;

    assign has_outst = (count != '0);
    // Only the registered count gates issue; a pop this cycle frees its slot next cycle.
    assign can_issue = (count < MAX_CNT);

    // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
    always_comb begin
        int      idx;
        req_id_t cand;
        pick_vld = 1'b0;
        pick_id  = '0;
        idx      = 0;
        cand     = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= int'(NUM_REQ)) idx = idx - int'(NUM_REQ);
            cand = IDW'(idx);
            if (!pick_vld && req_valid_i[cand]) begin
                pick_vld = 1'b1;
                pick_id  = cand;
            end
        end
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        grant_vld = 1'b0;
        grant_id  = pick_id;

        unique case (state_q)
            ARB: begin
                grant_vld = pick_vld && can_issue;
                grant_id  = pick_id;
            end
            LOCK: begin
                grant_vld = 1'b1;
                grant_id  = lock_id_q;
            end
            default: ;
        endcase

        if (flush_i) grant_vld = 1'b0;
        accept = grant_vld && ppu_in_ready_i;

        if (flush_i) begin
            state_d = ARB;
        end else if (accept) begin
            state_d  = ARB;
            rr_ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        end else if (grant_vld) begin
            state_d   = LOCK;
            lock_id_d = grant_id;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB;
            rr_ptr_q  <= '0;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    assign ppu_in_valid_o = grant_vld && rst_ni;
    assign ppu_flush_o    = flush_i;
    assign ppu_operands_o = req_operands_i[grant_id];
    assign ppu_op_o       = req_op_i[grant_id];
    assign ppu_op_mod_o   = req_op_mod_i[grant_id];
    assign ppu_rnd_mode_o = req_rnd_mode_i[grant_id];
    assign ppu_src_fmt_o  = req_src_fmt_i[grant_id];
    assign ppu_dst_fmt_o  = req_dst_fmt_i[grant_id];
    assign ppu_int_fmt_o  = req_int_fmt_i[grant_id];

    always_comb begin
        req_ready_o           = '0;
        req_ready_o[grant_id] = accept && rst_ni;
    end

    posit_id_fifo #(
        .DEPTH (MAX_OUTST),
        .DW    (IDW)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (flush_i),
        .push_i      (accept),
        .push_data_i (grant_id),
        .pop_i       (pop),
        .head_o      (head_id),
        .count_o     (count)
    );

    // Results come back in issue order, so the FIFO head owns the current result.
    always_comb begin
        rsp_valid_o          = '0;
        rsp_valid_o[head_id] = ppu_out_valid_i && has_outst && !flush_i && rst_ni;
    end

    assign ppu_out_ready_o = has_outst && rsp_ready_i[head_id] && rst_ni;
    assign pop             = ppu_out_valid_i && ppu_out_ready_o;
    assign rsp_result_o    = ppu_result_i;
    assign rsp_status_o    = ppu_status_i;
    assign busy_o          = has_outst || ppu_busy_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            protocol_err_o <= 1'b0;
        end else if (ppu_out_valid_i && !has_outst) begin
            protocol_err_o <= 1'b1;
        end
    end

endmodule

// File: doc/posit_issue_arbiter.md
Name: posit_issue_arbiter

Overview:
Shares one posit_top PPU instance between NUM_REQ independent requesters, such as the integer-core offload port and a debug or accelerator port.
- Arbitrates issue with round-robin priority and holds a grant until the PPU accepts the operation.
- Records the requester ID of every issued operation in an in-order ID FIFO and routes each PPU result back to its owner.
- posit_top returns results in issue order; this is a fixed property of the PPU this block relies on.

Parameters:
NUM_REQ, 2, number of requester ports (≥2).
WIDTH, 32, posit/operand width.
NUM_OPERANDS, 3, operands per operation.
MAX_OUTST, 4, maximum operations in flight inside the PPU (ID FIFO depth, power of 2).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  NUM_REQ  per-requester operation valid.
req_ready_o  out  NUM_REQ  per-requester accept.
req_operands_i  in  NUM_REQ×NUM_OPERANDS×WIDTH  operands per requester.
req_op_i  in  NUM_REQ×operation_e  operation.
req_op_mod_i  in  NUM_REQ  op modifier.
req_rnd_mode_i  in  NUM_REQ×roundmode_e  rounding mode.
req_src_fmt_i / req_dst_fmt_i  in  NUM_REQ×posit_format_e  formats.
req_int_fmt_i  in  NUM_REQ×int_format_e  integer format.
rsp_valid_o  out  NUM_REQ  one-hot result valid.
rsp_ready_i  in  NUM_REQ  per-requester result accept.
rsp_result_o  out  WIDTH  result (broadcast).
rsp_status_o  out  status_t  status (broadcast).
flush_i  in  1  abort everything in flight.
ppu_* (operands, op, op_mod, rnd_mode, src/dst/int fmt, in_valid, flush)  out  —  driven to posit_top.
ppu_in_ready_i, ppu_out_valid_i, ppu_result_i, ppu_status_i, ppu_busy_i  in  —  from posit_top.
ppu_out_ready_o  out  1  to posit_top.
busy_o  out  1  count≠0 or ppu_busy_i.
protocol_err_o  out  1  sticky: PPU produced a result with the ID FIFO empty.

Behaviour:
- Reset (asynchronous): FSM=ARB, rr_ptr=0, FIFO rd/wr pointers and count=0, protocol_err_o=0. All valid and ready outputs are 0 while in reset.
- FSM ARB:
  - Pick the first requester with req_valid_i set, scanning from rr_ptr upward and wrapping modulo NUM_REQ.
  - Issue only if count<MAX_OUTST. A same-cycle pop does not free a slot; there is no combinational path from ppu_out to ppu_in.
  - On grant, drive ppu_in_valid_o=1 and mux that requester's fields onto ppu_*.
  - If ppu_in_ready_i=1 in the same cycle: req_ready_o[g]=1, push g, rr_ptr←g+1 mod NUM_REQ, stay in ARB.
  - Otherwise latch g and go to LOCK.
- FSM LOCK:
  - The grant is frozen to the latched g; ppu_in_valid_o=1 and fields come combinationally from requester g.
  - A requester must hold valid and fields stable until accepted.
  - On ppu_in_ready_i: accept, push, rr_ptr←g+1, go to ARB.
- Response path:
  - head = FIFO[rd].
  - rsp_valid_o = onehot(head) & {NUM_REQ{ppu_out_valid_i & count≠0}}.
  - ppu_out_ready_o = (count≠0) & rsp_ready_i[head].
  - Pop when ppu_out_valid_i & ppu_out_ready_o.
  - rsp_result_o and rsp_status_o pass straight through from ppu_result_i and ppu_status_i.
- Push and pop in the same cycle: count unchanged, both pointers advance, wrapping modulo MAX_OUTST.
- Full (count=MAX_OUTST): no grant is issued and ppu_in_valid_o=0. Responses still drain.
- PPU result with count=0: ppu_out_ready_o=0, protocol_err_o←1 (sticky until reset).
- flush_i=1:
  - ppu_flush_o=1 in the same cycle; ppu_in_valid_o and all req_ready_o forced to 0.
  - Next state: FIFO pointers and count=0, FSM=ARB.
  - rr_ptr is preserved.
  - rsp_valid_o is forced to 0 during the flush cycle.
- Latency: an operation can be accepted in the cycle it is presented. The response adds 0 cycles over PPU latency.

Decomposition:
- posit_pkg: add arb_state_e {ARB, LOCK} and the req_id_t width constant $clog2(NUM_REQ).
- posit_pkg already holds operation_e, roundmode_e, posit_format_e, int_format_e, status_t.
- One natural sub-module: posit_id_fifo (synchronous FIFO with count and clear input), instantiated with depth MAX_OUTST and width $clog2(NUM_REQ).

Test Plan:
1. Fairness: req0 and req1 both valid, ppu_in_ready_i=1 constantly, MUL ops → grants alternate 0,1,0,1. The ID FIFO order matches, and each rsp_valid_o goes only to the issuer.
2. Lock hold: req1 valid with ADD, ppu_in_ready_i low for 3 cycles; req0 raises valid in cycle 2 → ppu_in_valid_o stays on req1's fields with no switch. req1 is accepted in cycle 4 and req0 is granted next.
3. Full: MAX_OUTST=4, issue 4 DIVs with ppu_out_valid_i=0 → the 5th request sees req_ready_o=0. One result popped → the next cycle issues.
4. Response backpressure: head=req0, rsp_ready_i[0]=0, ppu_out_valid_i=1 with result 0x48E00000 → ppu_out_ready_o=0 and result held. Raising rsp_ready_i[0] → pop, count decrements.
5. Flush: 3 in flight, flush_i pulse → ppu_flush_o=1, count=0 next cycle, busy_o follows ppu_busy_i only, rr_ptr unchanged.
6. Spurious result: count=0, ppu_out_valid_i=1 → protocol_err_o=1 and stays set; async rst_ni low clears it immediately.
